// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-hazard inputs and stage-control outputs of hazard_ctrl.
// Optional macro HAZARD_CTRL_PERF_EN adds the stall/flush performance-counter signals.
interface hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5
`ifdef HAZARD_CTRL_PERF_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
);
  // Hazard sources from ID, EX and MEM
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rt;
  logic              ex_memread;
  logic [REG_AW-1:0] ex_rt;
  logic              mem_branch_taken;
  logic              mem_req;
  logic              dmem_ready;

  // Pipeline-register controls and status
  logic              pc_en;
  logic              if_id_en;
  logic              id_ex_en;
  logic              ex_mem_en;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              ex_mem_flush;
  logic              mem_wb_bubble;
  logic              mem_timeout;
  logic [1:0]        state;
`ifdef HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
`endif

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
           mem_branch_taken, mem_req, dmem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble,
           mem_timeout, state
`ifdef HAZARD_CTRL_PERF_EN
    ,
    input  stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
           mem_branch_taken, mem_req, dmem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble,
           mem_timeout, state
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage MIPS pipeline sequencer (load-use stall, branch flush,
// data-memory wait with watchdog). Optional macro HAZARD_CTRL_PERF_EN adds
// saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);
  localparam int unsigned WCNT_W = 8;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  // Reject parameter values the counters cannot represent
  if (TIMEOUT < 1 || TIMEOUT > 255 || CNT_W < 1 || REG_AW < 1) begin : g_bad_cfg
    $error("hazard_ctrl: illegal parameter set");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic [WCNT_W-1:0] w_wait_cnt_nxt;
  logic [WCNT_W:0]   w_cnt_inc;
  logic              r_timeout;
  logic              w_wait;
  logic              w_lu;
  logic              w_fire;
  logic              w_br_act;
  logic              w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en;
  logic              w_if_id_flush, w_id_ex_flush, w_ex_mem_flush, w_mem_wb_bubble;

  assign w_wait = bus.mem_req && !bus.dmem_ready;
  assign w_lu   = bus.ex_memread && (bus.ex_rt != '0) &&
                  ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
  assign w_cnt_inc = (WCNT_W+1)'(r_wait_cnt) + (WCNT_W+1)'(1);

  // Next state, wait counter and stage controls; priority reset > wait > branch > load-use
  always_comb begin
    w_state_nxt     = RUN;
    w_wait_cnt_nxt  = '0;
    w_fire          = 1'b0;
    w_br_act        = 1'b0;
    w_pc_en         = 1'b1;
    w_if_id_en      = 1'b1;
    w_id_ex_en      = 1'b1;
    w_ex_mem_en     = 1'b1;
    w_if_id_flush   = 1'b0;
    w_id_ex_flush   = 1'b0;
    w_ex_mem_flush  = 1'b0;
    w_mem_wb_bubble = 1'b0;
    if (!rst) begin
      w_pc_en         = 1'b0;
      w_if_id_en      = 1'b0;
      w_id_ex_en      = 1'b0;
      w_ex_mem_en     = 1'b0;
      w_if_id_flush   = 1'b1;
      w_id_ex_flush   = 1'b1;
      w_ex_mem_flush  = 1'b1;
      w_mem_wb_bubble = 1'b1;
    end else begin
      // Watchdog: the TIMEOUT-th MEM_WAIT cycle is treated as a completed access
      w_fire = (r_state == MEM_WAIT) && w_wait && (w_cnt_inc == (WCNT_W+1)'(TIMEOUT));
      if (w_wait && !w_fire) begin
        w_pc_en         = 1'b0;
        w_if_id_en      = 1'b0;
        w_id_ex_en      = 1'b0;
        w_ex_mem_en     = 1'b0;
        w_mem_wb_bubble = 1'b1;
        w_state_nxt     = MEM_WAIT;
        if (r_state == MEM_WAIT) begin
          w_wait_cnt_nxt = w_cnt_inc[WCNT_W-1:0];
        end
      end else if (bus.mem_branch_taken && (r_state != FLUSH)) begin
        // A branch held in MEM during a wait is taken on release
        w_br_act       = 1'b1;
        w_if_id_flush  = 1'b1;
        w_id_ex_flush  = 1'b1;
        w_ex_mem_flush = 1'b1;
        w_state_nxt    = FLUSH;
      end else if (w_lu && (r_state == RUN)) begin
        w_pc_en       = 1'b0;
        w_if_id_en    = 1'b0;
        w_id_ex_flush = 1'b1;
        w_state_nxt   = LU_STALL;
      end
    end
  end

  // State, wait counter and sticky watchdog flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_fire) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign bus.pc_en         = w_pc_en;
  assign bus.if_id_en      = w_if_id_en;
  assign bus.id_ex_en      = w_id_ex_en;
  assign bus.ex_mem_en     = w_ex_mem_en;
  assign bus.if_id_flush   = w_if_id_flush;
  assign bus.id_ex_flush   = w_id_ex_flush;
  assign bus.ex_mem_flush  = w_ex_mem_flush;
  assign bus.mem_wb_bubble = w_mem_wb_bubble;
  assign bus.mem_timeout   = r_timeout;
  assign bus.state         = 2'(r_state);

`ifdef HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Saturating counts of frozen-PC cycles and branch flushes
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_pc_en && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_br_act && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
`endif
endmodule
